// File: rtl/edge_detection_pkg.sv
// Shared definitions for the edge-detection frame scheduler.
//   fsm_state_t : frame controller states
//   NB_*        : bit positions of the 3x3 neighbourhood inside win_pixels
//   MODE_*      : values of the per-frame step selector
package edge_detection_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    DRAIN  = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } fsm_state_t;

  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_R  = 3;
  localparam int NB_BR = 4;
  localparam int NB_B  = 5;
  localparam int NB_BL = 6;
  localparam int NB_L  = 7;
  localparam int NB_C  = 8;

  localparam logic MODE_STEP1 = 1'b0;
  localparam logic MODE_STEP2 = 1'b1;

endpackage

// File: rtl/edge_detection_window_buf.sv
// Two-line history buffer plus 3x3 window tap with border masking.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   shift_en    : shift pix into the history this cycle
//   pix         : incoming pixel (real or virtual zero)
//   col, row    : raster position of the incoming pixel; row runs past
//                 HEIGHT-1 while virtual pixels are injected
//   win_pixels_o: registered, masked neighbourhood of the centre pixel
//   win_valid_o : one-cycle pulse, win_pixels_o holds a new window
module edge_detection_window_buf
  import edge_detection_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             pix,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W:0]   row,
  output logic [8:0]       win_pixels_o,
  output logic             win_valid_o
);

  // History of the last 2*WIDTH+2 pixels; sr_d[0] is the incoming pixel.
  // The centre is WIDTH+1 pixels behind the incoming one, so the incoming
  // pixel is always the bottom-right neighbour.
  localparam int SR_LEN = 2 * WIDTH + 2;

  logic [SR_LEN-1:0] sr_q;
  logic [SR_LEN:0]   sr_d;
  logic [8:0]        win_q;
  logic              valid_q;

  logic [COL_W-1:0]  ccol;
  logic [ROW_W:0]    crow;
  logic              issue;
  logic [8:0]        win_raw;
  logic [8:0]        kill;

  assign sr_d = {sr_q, pix};

  always_comb begin
    ccol  = (col == '0) ? COL_W'(WIDTH - 1) : col - COL_W'(1);
    crow  = (col == '0) ? row - (ROW_W+1)'(2) : row - (ROW_W+1)'(1);
    // A window exists once WIDTH+1 pixels are in the history.
    issue = (row >= (ROW_W+1)'(2)) || ((row == (ROW_W+1)'(1)) && (col != '0));

    win_raw        = '0;
    win_raw[NB_BR] = sr_d[0];
    win_raw[NB_B]  = sr_d[1];
    win_raw[NB_BL] = sr_d[2];
    win_raw[NB_R]  = sr_d[WIDTH];
    win_raw[NB_C]  = sr_d[WIDTH+1];
    win_raw[NB_L]  = sr_d[WIDTH+2];
    win_raw[NB_TR] = sr_d[2*WIDTH];
    win_raw[NB_T]  = sr_d[2*WIDTH+1];
    win_raw[NB_TL] = sr_d[2*WIDTH+2];

    // Masking also hides pixels from the neighbouring row that wrap into
    // the left/right taps, and stale history from a previous frame.
    kill = '0;
    if (ccol == '0) begin
      kill[NB_TL] = 1'b1; kill[NB_L] = 1'b1; kill[NB_BL] = 1'b1;
    end
    if (ccol == COL_W'(WIDTH - 1)) begin
      kill[NB_TR] = 1'b1; kill[NB_R] = 1'b1; kill[NB_BR] = 1'b1;
    end
    if (crow == '0) begin
      kill[NB_TL] = 1'b1; kill[NB_T] = 1'b1; kill[NB_TR] = 1'b1;
    end
    if (crow == (ROW_W+1)'(HEIGHT - 1)) begin
      kill[NB_BL] = 1'b1; kill[NB_B] = 1'b1; kill[NB_BR] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= shift_en && issue;
      if (shift_en) begin
        sr_q <= sr_d[SR_LEN-1:0];
        if (issue) win_q <= win_raw & ~kill;
      end
    end
  end

  assign win_pixels_o = win_q;
  assign win_valid_o  = valid_q;

endmodule

// File: rtl/edge_detection_scheduler.sv
// Frame-level controller for the edge-detection step units.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start, mode         : frame start pulse and step selection (IDLE only)
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
//   in_valid/in_ready/in_pixel   : raster input stream
//   win_pixels, win_valid        : neighbourhood issue to the step units
//   step_sel, step_state         : latched mode / selected unit result
//   out_valid/out_ready/out_pixel/out_last : raster output stream
//   dbg_state           : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, and an offered output
// holds its data until it is taken.
module edge_detection_scheduler
  import edge_detection_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_pixel,
  output logic [8:0] win_pixels,
  output logic       win_valid,
  output logic       step_sel,
  input  logic       step_state,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_pixel,
  output logic       out_last,
  output logic [2:0] dbg_state
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int OC_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  fsm_state_t       state_q, state_d;
  logic             step_sel_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W:0]   row_q;     // one extra bit: rows HEIGHT..HEIGHT+1 during drain
  logic [OC_W-1:0]  out_cnt_q;
  logic [1:0]       occ_q;
  logic [1:0]       mem_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic             res_pend_q; // step result due this cycle

  logic [2:0] load;
  logic       credit_ok;
  logic       in_hs, inject, shift_en, shift_pix;
  logic       last_in, last_inj;
  logic       push, pop;
  logic       start_ok;

  // Windows in flight are those at the step units and those whose result
  // is due; together with FIFO occupancy they must never exceed 2.
  assign load      = 3'(occ_q) + 3'(win_valid) + 3'(res_pend_q);
  assign credit_ok = load < 3'd2;

  assign start_ok  = (state_q == IDLE) && start;
  assign in_hs     = in_valid && in_ready;
  assign inject    = (state_q == DRAIN) && credit_ok;
  assign shift_en  = in_hs || inject;
  assign shift_pix = in_hs ? in_pixel : 1'b0;

  assign last_in  = (col_q == COL_W'(WIDTH - 1)) && (row_q == (ROW_W+1)'(HEIGHT - 1));
  assign last_inj = (col_q == '0) && (row_q == (ROW_W+1)'(HEIGHT + 1));

  assign push = res_pend_q;
  assign pop  = out_valid && out_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: if (in_hs && last_in) state_d = DRAIN;
      DRAIN:  if (inject && last_inj) state_d = FLUSH;
      FLUSH:  if (!push && !win_valid &&
                  ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      STREAM: begin in_ready = credit_ok; busy = 1'b1; end
      DRAIN:  busy = 1'b1;
      FLUSH:  busy = 1'b1;
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  // Frame setup and raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_sel_q <= MODE_STEP1;
      col_q      <= '0;
      row_q      <= '0;
    end else if (start_ok) begin
      step_sel_q <= mode;
      col_q      <= '0;
      row_q      <= '0;
    end else if (shift_en) begin
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_q <= '0;
        row_q <= row_q + (ROW_W+1)'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  // Result capture and 2-entry output FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_pend_q <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
      out_cnt_q  <= '0;
    end else begin
      res_pend_q <= win_valid;
      if (push) begin
        mem_q[wr_ptr_q] <= step_state;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + OC_W'(1);
      end
      if (start_ok) out_cnt_q <= '0;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_pixel = out_valid && mem_q[rd_ptr_q];
  assign out_last  = out_valid && (out_cnt_q == OC_W'(NPIX - 1));
  assign step_sel  = step_sel_q;

  edge_detection_window_buf #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_window_buf (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .pix         (shift_pix),
    .col         (col_q),
    .row         (row_q),
    .win_pixels_o(win_pixels),
    .win_valid_o (win_valid)
  );

endmodule

// File: tb/tb_edge_detection_scheduler.sv
module tb_edge_detection_scheduler;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, mode = 1'b0;
  logic       in_valid = 1'b0, in_pixel = 1'b0;
  logic       out_ready = 1'b0;
  logic       step_state;
  logic       busy, done, in_ready, win_valid, step_sel;
  logic       out_valid, out_pixel, out_last;
  logic [8:0] win_pixels;
  logic [2:0] dbg_state;

  edge_detection_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .win_pixels(win_pixels), .win_valid(win_valid),
    .step_sel(step_sel), .step_state(step_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // step unit stub: registers one selected neighbour bit
  logic [3:0] stub_sel = 4'd8;
  always @(posedge clk or negedge rst) begin
    if (!rst) step_state <= 1'b0;
    else      step_state <= win_pixels[stub_sel];
  end

  // downstream ready: 0 = always ready, 1 = pattern 1,0,0,1
  int ready_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    phase++;
    out_ready = (ready_mode == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
  end

  // output monitor (scoreboard collection)
  logic got_q[$];
  int   cyc = 0, last_cnt = 0, last_pos = 0, last_cyc = 0;
  int   done_cnt = 0, done_cyc = 0, stab_err = 0;
  logic prev_stall = 1'b0, prev_pix = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_pixel !== prev_pix)) stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pixel;
      if (out_valid && out_ready) begin
        got_q.push_back(out_pixel);
        if (out_last) begin
          last_cnt++;
          last_pos = got_q.size();
          last_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int   checks = 0, passes = 0;
  int   blocked = 0;
  logic busy_after_start, busy_after_done;

  function automatic logic [15:0] got_vec();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < got_q.size() && i < 16; i++) v[i] = got_q[i];
    return v;
  endfunction

  // driver: start a frame, stream n_pix pixels, optionally wait for done
  task automatic run_frame(input logic m, input logic [15:0] pix, input int n_pix,
                           input int pulse_at, input bit wait_done);
    int idx, budget;
    logic hs;
    @(posedge clk); #1;
    got_q.delete();
    last_cnt = 0; last_pos = 0; last_cyc = 0; stab_err = 0; blocked = 0;
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; busy_after_start = busy;
    idx = 0; budget = 0;
    while (idx < n_pix && budget < 400) begin
      in_valid = 1'b1;
      in_pixel = pix[idx];
      start    = (budget == pulse_at);
      mode     = start ? ~m : m;
      hs       = in_ready;
      if (!hs) blocked++;
      @(negedge clk);
      if (hs) idx++;
      budget++;
    end
    in_valid = 1'b0; start = 1'b0; mode = m;
    checks++;
    if (idx != n_pix) $display("FAIL input_timeout: accepted %0d pixels, required %0d", idx, n_pix);
    else passes++;
    if (wait_done) begin
      budget = 0;
      while (!done && budget < 300) begin
        @(negedge clk);
        budget++;
      end
      checks++;
      if (!done) $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
      else passes++;
      @(negedge clk);
      busy_after_done = busy;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, in_ready, win_valid, out_valid, out_pixel, out_last} !== 7'b0)
      $display("FAIL reset_outputs: got %b, required 0000000",
               {busy, done, in_ready, win_valid, out_valid, out_pixel, out_last});
    else passes++;
    checks++;
    if (win_pixels !== 9'b0) $display("FAIL reset_win: got %b, required 0", win_pixels);
    else passes++;
    checks++;
    if (step_sel !== 1'b0) $display("FAIL reset_step_sel: got %b, required 0", step_sel);
    else passes++;
    checks++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state);
    else passes++;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity();
    int d0;
    stub_sel = 4'd8; ready_mode = 0; d0 = done_cnt;
    run_frame(1'b0, 16'h8F4D, N, -1, 1'b1);
    checks++;
    if (busy_after_start !== 1'b1) $display("FAIL id_busy_start: got %b, required 1", busy_after_start);
    else passes++;
    checks++;
    if (got_q.size() != N) $display("FAIL id_count: got %0d, required %0d", got_q.size(), N);
    else passes++;
    checks++;
    if (got_vec() !== 16'h8F4D) $display("FAIL id_data: got %h, required 8f4d", got_vec());
    else passes++;
    checks++;
    if (last_cnt != 1 || last_pos != N) $display("FAIL id_last: got %0d at pos %0d, required 1 at %0d", last_cnt, last_pos, N);
    else passes++;
    checks++;
    if (done_cyc != last_cyc + 1) $display("FAIL id_done_timing: got cycle %0d, required %0d", done_cyc, last_cyc + 1);
    else passes++;
    checks++;
    if (done_cnt - d0 != 1) $display("FAIL id_done_count: got %0d, required 1", done_cnt - d0);
    else passes++;
    checks++;
    if (busy_after_done !== 1'b0) $display("FAIL id_busy_end: got %b, required 0", busy_after_done);
    else passes++;
  endtask

  task automatic test_top_mask();
    stub_sel = 4'd1; ready_mode = 0;
    run_frame(1'b0, 16'hFFFF, N, -1, 1'b1);
    checks++;
    if (got_q.size() != N || got_vec() !== 16'hFFF0)
      $display("FAIL top_mask: got %h (%0d px), required fff0 (16 px)", got_vec(), got_q.size());
    else passes++;
  endtask

  task automatic test_right_mask();
    stub_sel = 4'd3; ready_mode = 0;
    run_frame(1'b0, 16'hFFFF, N, -1, 1'b1);
    checks++;
    if (got_q.size() != N || got_vec() !== 16'h7777)
      $display("FAIL right_mask: got %h (%0d px), required 7777 (16 px)", got_vec(), got_q.size());
    else passes++;
  endtask

  task automatic test_backpressure();
    stub_sel = 4'd8; ready_mode = 1;
    run_frame(1'b0, 16'hA5C3, N, -1, 1'b1);
    checks++;
    if (got_q.size() != N || got_vec() !== 16'hA5C3)
      $display("FAIL bp_data: got %h (%0d px), required a5c3 (16 px)", got_vec(), got_q.size());
    else passes++;
    checks++;
    if (stab_err != 0) $display("FAIL bp_hold: got %0d unstable stalls, required 0", stab_err);
    else passes++;
    checks++;
    if (blocked == 0) $display("FAIL bp_in_ready: got 0 blocked cycles, required >0");
    else passes++;
    checks++;
    if (last_cnt != 1 || last_pos != N) $display("FAIL bp_last: got %0d at pos %0d, required 1 at %0d", last_cnt, last_pos, N);
    else passes++;
    ready_mode = 0;
  endtask

  task automatic test_reset_midframe();
    int d0;
    stub_sel = 4'd8; ready_mode = 0;
    run_frame(1'b0, 16'h8F4D, 7, -1, 1'b0);
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, in_ready, win_valid, out_valid, out_pixel, out_last, step_sel} !== 8'b0 ||
        win_pixels !== 9'b0)
      $display("FAIL midreset_outputs: got %b/%b, required all 0",
               {busy, done, in_ready, win_valid, out_valid, out_pixel, out_last, step_sel}, win_pixels);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(1'b1, 16'h8F4D, N, -1, 1'b1);
    checks++;
    if (step_sel !== 1'b1) $display("FAIL midreset_step_sel: got %b, required 1", step_sel);
    else passes++;
    checks++;
    if (got_q.size() != N || got_vec() !== 16'h8F4D)
      $display("FAIL midreset_data: got %h (%0d px), required 8f4d (16 px)", got_vec(), got_q.size());
    else passes++;
    checks++;
    if (done_cnt - d0 != 1) $display("FAIL midreset_done: got %0d, required 1", done_cnt - d0);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int d0;
    stub_sel = 4'd8; ready_mode = 0; d0 = done_cnt;
    run_frame(1'b0, 16'h3C96, N, 5, 1'b1);
    checks++;
    if (step_sel !== 1'b0) $display("FAIL start_ign_step_sel: got %b, required 0", step_sel);
    else passes++;
    checks++;
    if (got_q.size() != N || got_vec() !== 16'h3C96)
      $display("FAIL start_ign_data: got %h (%0d px), required 3c96 (16 px)", got_vec(), got_q.size());
    else passes++;
    checks++;
    if (done_cnt - d0 != 1) $display("FAIL start_ign_done: got %0d, required 1", done_cnt - d0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_top_mask();
    test_right_mask();
    test_backpressure();
    test_reset_midframe();
    test_start_ignored();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
